ysyx_22041211_store_unit: RTL and testbench

Store-path data formatter and memory write sequencer for the NPC core; the write-side counterpart of the load-path sign/zero extender. It accepts a store (address, register data, size) from the execute stage, narrows and replicates the data into byte lanes, and generates the byte mask. It then drives one write transaction to data memory with a valid/ready handshake and reports completion or error back to the pipeline. Misaligned and illegal-size stores are trapped without touching memory, and a stalled memory is bounded by a timeout.

---
 rtl/ysyx_22041211_store_unit.sv | 116 +++++++++++
 tb/tb_ysyx_22041211_store_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_store_unit.sv
// ysyx_22041211_store_unit: store-path lane formatter and single-beat memory write sequencer.
// Rev 1.0 - initial release.
`default_nettype none

module ysyx_22041211_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  resp_valid,
  output logic                  resp_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESP     = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        err;
  logic        bad_req;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wmask;

  // Narrow and replicate the store data into lanes; flag anything that cannot be issued.
  always_comb begin
    bad_req   = 1'b0;
    fmt_wdata = 32'd0;
    fmt_wmask = 4'd0;
    case (req_size)
      2'b00: begin
        fmt_wdata = {4{req_data[7:0]}};
        fmt_wmask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        bad_req   = req_addr[0];
        fmt_wdata = {2{req_data[15:0]}};
        fmt_wmask = 4'b0011 << {req_addr[1], 1'b0};
      end
      2'b10: begin
        bad_req   = |req_addr[1:0];
        fmt_wdata = req_data;
        fmt_wmask = 4'b1111;
      end
      default: bad_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (req_valid) begin
            if (bad_req) begin
              err   <= 1'b1;
              state <= RESP;
            end else begin
              err       <= 1'b0;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= fmt_wdata;
              mem_wmask <= fmt_wmask;
              state     <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // A ready arriving on the last allowed cycle still counts as success.
          if (mem_ready || cnt == CNT_LAST) begin
            err       <= ~mem_ready;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          cnt   <= 8'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign mem_valid  = (state == WAIT_MEM);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041211_store_unit.sv
// Testbench for ysyx_22041211_store_unit: vector table plus response scoreboard.
`default_nettype none

module tb_ysyx_22041211_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic        req_valid = 1'b0, req_ready, mem_valid, mem_ready = 1'b0, resp_valid, resp_err;
  logic [31:0] req_addr = '0, req_data = '0, mem_addr, mem_wdata;
  logic [1:0]  req_size = '0;
  logic [3:0]  mem_wmask;

  // Short-timeout instance
  logic        req_valid1 = 1'b0, req_ready1, mem_valid1, mem_ready1 = 1'b0, resp_valid1, resp_err1;
  logic [31:0] req_addr1 = '0, req_data1 = '0, mem_addr1, mem_wdata1;
  logic [1:0]  req_size1 = '0;
  logic [3:0]  mem_wmask1;

  ysyx_22041211_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  ysyx_22041211_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .req_data(req_data1), .req_size(req_size1),
    .mem_valid(mem_valid1), .mem_ready(mem_ready1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
    .resp_valid(resp_valid1), .resp_err(resp_err1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          delay;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare a response pulse against the oldest queued expectation.
  task automatic check_resp(input string name);
    logic e;
    check({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_scoreboard: got response expected none queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_resp_err"}, {31'd0, resp_err}, {31'd0, e});
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    check({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
    exp_q.push_back(v.exp_err);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exp_err) begin
      check({name, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
      check_resp(name);
    end else begin
      for (int k = 0; k <= v.delay; k++) begin
        check({name, "_mem_valid"}, {31'd0, mem_valid}, 32'd1);
        check({name, "_mem_addr"}, mem_addr, v.exp_addr);
        check({name, "_wdata"}, mem_wdata, v.exp_wdata);
        check({name, "_wmask"}, {28'd0, mem_wmask}, {28'd0, v.exp_wmask});
        check({name, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
        check({name, "_early_resp"}, {31'd0, resp_valid}, 32'd0);
        mem_ready = (k == v.delay);
        @(negedge clk);
      end
      mem_ready = 1'b0;
      check_resp(name);
      check({name, "_valid_drop"}, {31'd0, mem_valid}, 32'd0);
      check({name, "_wdata_idle"}, mem_wdata, 32'd0);
      check({name, "_wmask_idle"}, {28'd0, mem_wmask}, 32'd0);
    end
    @(negedge clk);
    check({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    check({name, "_resp_one"}, {31'd0, resp_valid}, 32'd0);
  endtask

  vec_t vecs[9];
  int   n_valid;

  initial begin
    vecs[0] = '{32'h8000_0003, 32'h1234_56AB, 2'b00, 0, 1'b0, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{32'h8000_0002, 32'hDEAD_BEEF, 2'b01, 0, 1'b0, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2] = '{32'h8000_0004, 32'hCAFE_F00D, 2'b10, 0, 1'b0, 32'h8000_0004, 32'hCAFE_F00D, 4'b1111};
    vecs[3] = '{32'h8000_0001, 32'h0000_0055, 2'b00, 1, 1'b0, 32'h8000_0000, 32'h5555_5555, 4'b0010};
    vecs[4] = '{32'h8000_0000, 32'h1234_5678, 2'b01, 2, 1'b0, 32'h8000_0000, 32'h5678_5678, 4'b0011};
    vecs[5] = '{32'h0000_0010, 32'h0102_0304, 2'b10, 5, 1'b0, 32'h0000_0010, 32'h0102_0304, 4'b1111};
    vecs[6] = '{32'h8000_0002, 32'h1111_1111, 2'b10, 0, 1'b1, 32'h0, 32'h0, 4'b0};
    vecs[7] = '{32'h8000_0001, 32'h2222_2222, 2'b01, 0, 1'b1, 32'h0, 32'h0, 4'b0};
    vecs[8] = '{32'h8000_0000, 32'h3333_3333, 2'b11, 0, 1'b1, 32'h0, 32'h0, 4'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout on the TIMEOUT=4 instance: mem_valid exactly 4 cycles, then err response.
    @(negedge clk);
    req_valid1 = 1'b1; req_addr1 = 32'h8000_0008; req_data1 = 32'hA5A5_A5A5; req_size1 = 2'b10;
    @(negedge clk);
    req_valid1 = 1'b0;
    n_valid = 0;
    for (int k = 0; k < 20 && mem_valid1; k++) begin
      n_valid++;
      @(negedge clk);
    end
    check("to_valid_cycles", n_valid, 32'd4);
    check("to_resp_valid", {31'd0, resp_valid1}, 32'd1);
    check("to_resp_err", {31'd0, resp_err1}, 32'd1);
    @(negedge clk);
    check("to_ready_back", {31'd0, req_ready1}, 32'd1);
    // Ready on the final allowed cycle still succeeds.
    req_valid1 = 1'b1; req_size1 = 2'b00; req_addr1 = 32'h8000_0002; req_data1 = 32'h0000_00C3;
    @(negedge clk);
    req_valid1 = 1'b0;
    check("to2_wdata", mem_wdata1, 32'hC3C3_C3C3);
    check("to2_wmask", {28'd0, mem_wmask1}, 32'h4);
    repeat (3) @(negedge clk);
    mem_ready1 = 1'b1;
    @(negedge clk);
    mem_ready1 = 1'b0;
    check("to2_resp_valid", {31'd0, resp_valid1}, 32'd1);
    check("to2_resp_err", {31'd0, resp_err1}, 32'd0);

    // Asynchronous reset while waiting on memory.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0000; req_data = 32'h7777_7777; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    check("ar_mem_valid_before", {31'd0, mem_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_mem_valid_now", {31'd0, mem_valid}, 32'd0);
    check("ar_wmask_now", {28'd0, mem_wmask}, 32'd0);
    check("ar_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("ar_req_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ar_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_vec(vecs[2], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
